// File: rtl/pingpong_pkg.sv
// pingpong_pkg: types and constants shared by the pingpong game's counters and display.
//   CNT_W          width of the count buses (score, timers, display)
//   timer_state_t  countdown_timer FSM encoding
package pingpong_pkg;

    localparam int unsigned CNT_W = 9;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } timer_state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: command/status bundle between the game control FSM (master)
// and countdown_timer (slave).
//   load, load_val  master -> slave  one-cycle load strobe and the value to load
//   start, pause    master -> slave  one-cycle run/resume and freeze strobes
//   cnt_out         slave -> master  current count
//   busy, paused    slave -> master  high in RUN / HOLD
//   done            slave -> master  one-cycle pulse when the count decrements to zero
interface countdown_timer_if #(
    parameter int unsigned WIDTH = pingpong_pkg::CNT_W
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] cnt_out;
    logic             busy;
    logic             paused;
    logic             done;

    modport master (
        output load, load_val, start, pause,
        input  cnt_out, busy, paused, done
    );

    modport slave (
        input  load, load_val, start, pause,
        output cnt_out, busy, paused, done
    );
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: enable-gated modulo-PRESCALE counter.
//   clk_i    system clock
//   rst_n_i  synchronous reset, active HIGH (name kept from the system-level bus)
//   en_i     count enable
//   clr_i    synchronous clear, wins over en_i
//   tick_o   combinational, high while enabled at terminal count PRESCALE-1
module tick_prescaler #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    // 16 bits covers the full legal PRESCALE range of 1..65535.
    localparam logic [15:0] LastCnt = 16'(PRESCALE - 1);

    logic [15:0] pre_q;
    logic [15:0] pre_d;

    assign tick_o = en_i && (pre_q == LastCnt);

    always_comb begin
        pre_d = pre_q;
        if (clr_i) begin
            pre_d = '0;
        end else if (en_i) begin
            pre_d = tick_o ? '0 : pre_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable, prescaled down-counter with a single-cycle done pulse.
//   clk_i    system clock
//   rst_n_i  synchronous reset, active HIGH
//   bus      countdown_timer_if.slave: load/load_val/start/pause in,
//            cnt_out/busy/paused/done out (all registered)
// Command priority per cycle: reset > load > start > pause > prescaler tick.
module countdown_timer
    import pingpong_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned WIDTH    = CNT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    countdown_timer_if.slave     bus
);
    timer_state_t     state_q;
    logic [WIDTH-1:0] cnt_q;
    logic             busy_q;
    logic             paused_q;
    logic             done_q;
    logic             tick;
    logic             pre_clr;

    // A fresh run (or any load) starts a full prescale period; resume from HOLD
    // keeps the partial period.
    assign pre_clr = bus.load || (bus.start && (state_q == StIdle));

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_tick_prescaler (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (state_q == StRun),
        .clr_i   (pre_clr),
        .tick_o  (tick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                cnt_q <= bus.load_val;
                // Reloading zero while running aborts silently.
                if ((state_q == StRun) && (bus.load_val == '0)) begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            end else if (bus.start && (state_q != StRun)) begin
                // From IDLE a zero count has nothing to run; HOLD always resumes.
                if ((state_q == StHold) || (cnt_q != '0)) begin
                    state_q  <= StRun;
                    busy_q   <= 1'b1;
                    paused_q <= 1'b0;
                end
            end else if (bus.pause && (state_q == StRun)) begin
                // A tick landing on this edge is dropped.
                state_q  <= StHold;
                busy_q   <= 1'b0;
                paused_q <= 1'b1;
            end else if ((state_q == StRun) && tick) begin
                if (cnt_q == WIDTH'(1)) begin
                    cnt_q   <= '0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_q <= cnt_q - WIDTH'(1);
                end
            end
        end
    end

    assign bus.cnt_out = cnt_q;
    assign bus.busy    = busy_q;
    assign bus.paused  = paused_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: a PRESCALE=4 instance for the main
// scenarios and a PRESCALE=1 instance for the full-range run. Expected per-cycle
// observations {cnt_out, busy, paused, done} are queued when stimulus is driven
// and popped one per cycle against the DUT.
module tb_countdown_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    countdown_timer_if #(.WIDTH(9)) tif4 ();
    countdown_timer_if #(.WIDTH(9)) tif1 ();

    countdown_timer #(.PRESCALE(4), .WIDTH(9)) u_dut4 (
        .clk_i   (clk),
        .rst_n_i (rst),
        .bus     (tif4)
    );

    countdown_timer #(.PRESCALE(1), .WIDTH(9)) u_dut1 (
        .clk_i   (clk),
        .rst_n_i (rst),
        .bus     (tif1)
    );

    logic [11:0] obs4;
    logic [11:0] obs1;
    assign obs4 = {tif4.cnt_out, tif4.busy, tif4.paused, tif4.done};
    assign obs1 = {tif1.cnt_out, tif1.busy, tif1.paused, tif1.done};

    logic [11:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [11:0] mk(input logic [8:0] c, input logic b, input logic p,
                                       input logic d);
        return {c, b, p, d};
    endfunction

    // All stimulus and sampling happens 1ns after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic ld, input logic [8:0] val, input logic st, input logic pa);
        tif4.load = ld; tif4.load_val = val; tif4.start = st; tif4.pause = pa;
        step();
        tif4.load = 1'b0; tif4.start = 1'b0; tif4.pause = 1'b0;
    endtask

    task automatic drive1(input logic ld, input logic [8:0] val, input logic st, input logic pa);
        tif1.load = ld; tif1.load_val = val; tif1.start = st; tif1.pause = pa;
        step();
        tif1.load = 1'b0; tif1.start = 1'b0; tif1.pause = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        rst = 1'b1;
        step();
        step();
        vectors++;
        if (obs4 !== mk(9'd0, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", obs4, mk(9'd0, 1'b0, 1'b0, 1'b0));
        end
        rst = 1'b0;
        drive4(1'b1, 9'd5, 1'b0, 1'b0);
        drive4(1'b0, 9'd0, 1'b1, 1'b0);
        step();
        vectors++;
        if (obs4 !== mk(9'd5, 1'b1, 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL reset_prerun: got %h want %h", obs4, mk(9'd5, 1'b1, 1'b0, 1'b0));
        end
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 24; i++) exp_q.push_back(mk(9'd0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL reset_midrun[%0d]: got cnt=%0d busy=%b paused=%b done=%b want cnt=%0d busy=%b paused=%b done=%b",
                         i, obs4[11:3], obs4[2], obs4[1], obs4[0], e[11:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_basic_run();
        logic [11:0] e;
        drive4(1'b1, 9'd3, 1'b0, 1'b0);
        vectors++;
        if (obs4 !== mk(9'd3, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL basic_load: got %h want %h", obs4, mk(9'd3, 1'b0, 1'b0, 1'b0));
        end
        drive4(1'b0, 9'd0, 1'b1, 1'b0);
        // i = edges since start was sampled.
        for (int i = 0; i < 16; i++)
            exp_q.push_back(mk((i >= 12) ? 9'd0 : 9'(3 - i / 4), i < 12, 1'b0, i == 12));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL basic_run[%0d]: got cnt=%0d busy=%b paused=%b done=%b want cnt=%0d busy=%b paused=%b done=%b",
                         i, obs4[11:3], obs4[2], obs4[1], obs4[0], e[11:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_pause_resume();
        logic [11:0] e;
        drive4(1'b1, 9'd2, 1'b0, 1'b0);
        drive4(1'b0, 9'd0, 1'b1, 1'b0);
        exp_q.push_back(mk(9'd2, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(9'd2, 1'b1, 1'b0, 1'b0));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL pr_run1[%0d]: got %h want %h", i, obs4, e);
            end
        end
        drive4(1'b0, 9'd0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) exp_q.push_back(mk(9'd2, 1'b0, 1'b1, 1'b0));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL pr_hold[%0d]: got %h want %h", i, obs4, e);
            end
        end
        drive4(1'b0, 9'd0, 1'b1, 1'b0);
        // Two edges of the period were used before the pause.
        for (int j = 0; j < 10; j++)
            exp_q.push_back(mk((j < 2) ? 9'd2 : ((j < 6) ? 9'd1 : 9'd0), j < 6, 1'b0, j == 6));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL pr_resume[%0d]: got cnt=%0d busy=%b paused=%b done=%b want cnt=%0d busy=%b paused=%b done=%b",
                         i, obs4[11:3], obs4[2], obs4[1], obs4[0], e[11:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_collisions();
        logic [11:0] e;
        drive4(1'b1, 9'd1, 1'b0, 1'b0);
        drive4(1'b0, 9'd0, 1'b1, 1'b0);
        step();
        step();
        step();
        // This edge would be the final tick.
        drive4(1'b1, 9'd7, 1'b0, 1'b0);
        for (int j = 0; j < 6; j++) exp_q.push_back(mk((j < 4) ? 9'd7 : 9'd6, 1'b1, 1'b0, 1'b0));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL load_on_tick[%0d]: got %h want %h", i, obs4, e);
            end
        end
        drive4(1'b1, 9'd0, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) exp_q.push_back(mk(9'd0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL reload_zero[%0d]: got %h want %h", i, obs4, e);
            end
        end
        drive4(1'b0, 9'd0, 1'b1, 1'b0);
        for (int j = 0; j < 6; j++) exp_q.push_back(mk(9'd0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL start_at_zero[%0d]: got %h want %h", i, obs4, e);
            end
        end
    endtask

    task automatic test_pause_final_tick();
        logic [11:0] e;
        drive4(1'b1, 9'd1, 1'b0, 1'b0);
        drive4(1'b0, 9'd0, 1'b1, 1'b0);
        step();
        step();
        step();
        drive4(1'b0, 9'd0, 1'b0, 1'b1);
        for (int j = 0; j < 6; j++) exp_q.push_back(mk(9'd1, 1'b0, 1'b1, 1'b0));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            vectors++;
            if (obs4 !== e) begin
                miscompares++;
                $display("FAIL pause_on_tick[%0d]: got %h want %h", i, obs4, e);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_prescale1();
        logic [11:0] e;
        drive1(1'b1, 9'd511, 1'b0, 1'b0);
        vectors++;
        if (obs1 !== mk(9'd511, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL p1_load: got %h want %h", obs1, mk(9'd511, 1'b0, 1'b0, 1'b0));
        end
        drive1(1'b0, 9'd0, 1'b1, 1'b0);
        for (int i = 0; i < 516; i++)
            exp_q.push_back(mk((i <= 511) ? 9'(511 - i) : 9'd0, i < 511, 1'b0, i == 511));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            vectors++;
            if (obs1 !== e) begin
                miscompares++;
                $display("FAIL p1_run[%0d]: got cnt=%0d busy=%b paused=%b done=%b want cnt=%0d busy=%b paused=%b done=%b",
                         i, obs1[11:3], obs1[2], obs1[1], obs1[0], e[11:3], e[2], e[1], e[0]);
            end
        end
    endtask

    initial begin
        tif4.load = 1'b0; tif4.load_val = '0; tif4.start = 1'b0; tif4.pause = 1'b0;
        tif1.load = 1'b0; tif1.load_val = '0; tif1.start = 1'b0; tif1.pause = 1'b0;
        #1;
        test_reset();
        test_basic_run();
        test_pause_resume();
        test_collisions();
        test_pause_final_tick();
        test_prescale1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable, prescaled down-counter for the pingpong game's round timing (serve countdown, rally timeout, display refresh windows). It is the counting-down, terminal-event counterpart of the team's free-running up-counter. It is loaded with a 9-bit value, decremented once per prescaler tick while running, and emits a single-cycle `done` pulse on reaching zero. It sits between the game control FSM (load/start/pause) and the score/display logic (`cnt_out`, `done`).

## Interface
- `PRESCALE`, default 50000: clk cycles per decrement; legal range 1..65535.
- `WIDTH`, default 9: counter width; matches the 9-bit count buses used elsewhere.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; synchronous and active-high (`rst_n`=1 resets on the next clk edge).
- `load`  in  1  one-cycle strobe; load `load_val` into the counter.
- `load_val`  in  WIDTH  value captured on `load`.
- `start`  in  1  one-cycle strobe; begin or resume counting.
- `pause`  in  1  one-cycle strobe; freeze counting.
- `cnt_out`  out  WIDTH  current count, registered.
- `busy`  out  1  high while in RUN.
- `paused`  out  1  high while in HOLD.
- `done`  out  1  one-cycle pulse when the count reaches 0 by decrementing.

## Operation
- States: IDLE, RUN, HOLD. All outputs are registered.
- Reset: state IDLE, `cnt_out`=0, prescaler=0, `busy`=0, `paused`=0, `done`=0. Reset applied mid-count discards the count and suppresses any pending `done`.
- Command priority per cycle: `rst_n` > `load` > `start` > `pause`. Lower-priority strobes in the same cycle are ignored.
- `load` in any state: `cnt_out`<=`load_val`, prescaler<=0.
  - RUN with nonzero `load_val`: stay in RUN.
  - RUN with `load_val`=0: go to IDLE, no `done`.
  - IDLE or HOLD: state unchanged.
- `start` in IDLE: if `cnt_out`≠0, go to RUN with prescaler<=0. If `cnt_out`=0, ignore.
- `start` in HOLD: go to RUN with the prescaler value retained (resume, no lost partial period).
- `start` in RUN: ignored.
- `pause` in RUN: go to HOLD; prescaler and count frozen. `pause` in IDLE or HOLD: ignored.
- RUN prescaler behaviour:
  - Prescaler counts 0..`PRESCALE`-1.
  - A tick occurs when prescaler=`PRESCALE`-1; the prescaler wraps to 0 and `cnt_out` decrements by 1.
  - On a tick with `cnt_out`=1: `cnt_out`<=0, `done`<=1 for exactly that cycle, state<=IDLE.
- The count never wraps below 0. The decrement is unsigned WIDTH-bit with no underflow path.
- `load` coinciding with a tick: `load` wins, no decrement, no `done`.
- `pause` coinciding with the final tick: the tick is lost (priority applies), state goes to HOLD with the count unchanged.

## Timing
- Latency from command to state: `load`, `start`, and `pause` take effect at the first clk edge where they are sampled high. Outputs reflect the new state in the following cycle.
- Decrement cadence: with `start` sampled at edge k from IDLE, the first decrement is visible after edge k+`PRESCALE`, then every `PRESCALE` edges.
- A run from value N with no pause takes N·`PRESCALE` cycles. `done` rises in the same cycle `cnt_out` becomes 0 and `busy` falls.
- `PRESCALE`=1 is legal: decrement every cycle while in RUN.
- `done` is never asserted for two consecutive cycles.

## Structure
- Shared package `pingpong_pkg`:
  - `timer_state_t` enum (IDLE=2'd0, RUN=2'd1, HOLD=2'd2).
  - `CNT_W`=9 constant, reused by the counters and the display.
- Sub-module `tick_prescaler` with ports `clk`, `rst_n`, `en`, `clr`, and output `tick`. It is an enable-gated modulo-`PRESCALE` counter whose `tick` is asserted combinationally at terminal count.
  - `en` = state==RUN.
  - `clr` = `load` or start-from-IDLE.
- Top level holds the FSM, the count register, and the `done` register.

## Test plan
- Tests run with `PRESCALE`=4 unless noted.
- Reset: hold `rst_n`=1 for 2 cycles mid-RUN with `cnt_out`=5 -> next cycle `cnt_out`=0, `busy`=0, `done`=0, no later `done`.
- Basic run: `load` 3, then `start` -> `cnt_out` steps 3→2→1→0 at 4-cycle intervals; `done` pulses once, 12 cycles after `start`; `busy` falls with it.
- Pause/resume: `load` 2, `start`, `pause` 2 cycles later, hold 10 cycles, `start` -> `cnt_out` stays 2 during HOLD; first decrement occurs 2 cycles after resume; total RUN time is 8 cycles.
- Collisions:
  - `load` 7 on the same cycle as the final tick -> `cnt_out`=7, no `done`, `busy` remains 1.
  - `start` with `cnt_out`=0 -> ignored.
- Reload to zero: in RUN, `load` 0 -> IDLE next cycle, `done` never asserted.
- `PRESCALE`=1: `load` 9'd511, `start` -> `done` exactly 511 cycles after `start`; `cnt_out` decrements every cycle with no underflow.
